// File: rtl/even_count_monitor.sv
// even_count_monitor: run-time checker for the 5-bit even counter sequence
// 0,2,...,30,0. It counts wraps and errors and captures the first bad value.
`default_nettype none

module even_count_monitor #(
  parameter int STEP    = 2,
  parameter int WRAP_W  = 8,
  parameter int ERR_W   = 8,
  parameter int RESYNC  = 1,
  parameter int HOLD_OK = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        count_in,
  input  logic              sample_en,
  input  logic              clear_err,
  output logic              locked,
  output logic [1:0]        state,
  output logic [4:0]        expected,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              err_flag,
  output logic [ERR_W-1:0]  err_count,
  output logic [4:0]        first_bad
);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'b00,
    ST_LOCK  = 2'b01,
    ST_FAULT = 2'b10
  } state_t;

  localparam logic [4:0] STEP_V = 5'(STEP);

  state_t     cur;
  logic [4:0] last;

  logic       is_odd;
  logic       match;
  logic       hold;
  logic       sample_err;
  logic [4:0] next_exp;

  assign is_odd   = count_in[0];
  assign match    = (count_in == expected);
  assign hold     = (HOLD_OK != 0) && (count_in == last);
  assign next_exp = count_in + STEP_V;
  assign state    = cur;

  // A rejected sample; clear_err wins over any simultaneous error.
  assign sample_err = sample_en && !clear_err &&
                      (((cur == ST_WAIT) && is_odd) ||
                       ((cur == ST_LOCK) && !match && !hold));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur        <= ST_WAIT;
      locked     <= 1'b0;
      last       <= '0;
      expected   <= '0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
      err_flag   <= 1'b0;
      err_count  <= '0;
      first_bad  <= '0;
    end else begin
      wrap_pulse <= 1'b0;
      if (clear_err) begin
        cur       <= ST_WAIT;
        locked    <= 1'b0;
        err_flag  <= 1'b0;
        err_count <= '0;
        first_bad <= '0;
      end else begin
        if (sample_err) begin
          if (err_count != '1) begin
            err_count <= err_count + ERR_W'(1);
          end
          if (!err_flag) begin
            first_bad <= count_in;
          end
          err_flag <= 1'b1;
        end

        case (cur)
          ST_WAIT: begin
            if (sample_en && !is_odd) begin
              last     <= count_in;
              expected <= next_exp;
              cur      <= ST_LOCK;
              locked   <= 1'b1;
            end
          end
          ST_LOCK: begin
            if (sample_en) begin
              if (match) begin
                last     <= count_in;
                expected <= next_exp;
                // A numeric drop on an accepted step means the counter wrapped.
                if (count_in < last) begin
                  wrap_pulse <= 1'b1;
                  wrap_count <= wrap_count + WRAP_W'(1);
                end
              end else if (!hold) begin
                if (RESYNC != 0) begin
                  if (!is_odd) begin
                    last     <= count_in;
                    expected <= next_exp;
                  end else begin
                    cur    <= ST_WAIT;
                    locked <= 1'b0;
                  end
                end else begin
                  cur    <= ST_FAULT;
                  locked <= 1'b0;
                end
              end
            end
          end
          ST_FAULT: begin
            cur <= ST_FAULT;
          end
          default: begin
            cur    <= ST_WAIT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_even_count_monitor.sv
// Bench for even_count_monitor: two configurations driven in parallel and
// compared every cycle against a behavioural model of the sequence rules.
`default_nettype none

module tb_even_count_monitor;

  localparam int STEP = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] count_in = '0;
  logic       sample_en = 1'b0;
  logic       clear_err = 1'b0;

  logic       a_locked, a_wrap_pulse, a_err_flag;
  logic [1:0] a_state;
  logic [4:0] a_expected, a_first_bad;
  logic [7:0] a_wrap_count, a_err_count;

  logic       b_locked, b_wrap_pulse, b_err_flag;
  logic [1:0] b_state;
  logic [4:0] b_expected, b_first_bad;
  logic [2:0] b_wrap_count;
  logic [1:0] b_err_count;

  always #5 clk = ~clk;

  even_count_monitor #(.STEP(2), .WRAP_W(8), .ERR_W(8), .RESYNC(1), .HOLD_OK(1)) dut_a (
    .clk(clk), .reset(reset), .count_in(count_in), .sample_en(sample_en),
    .clear_err(clear_err), .locked(a_locked), .state(a_state), .expected(a_expected),
    .wrap_pulse(a_wrap_pulse), .wrap_count(a_wrap_count), .err_flag(a_err_flag),
    .err_count(a_err_count), .first_bad(a_first_bad));

  // Second copy: no relock, no hold tolerance, narrow counters.
  even_count_monitor #(.STEP(2), .WRAP_W(3), .ERR_W(2), .RESYNC(0), .HOLD_OK(0)) dut_b (
    .clk(clk), .reset(reset), .count_in(count_in), .sample_en(sample_en),
    .clear_err(clear_err), .locked(b_locked), .state(b_state), .expected(b_expected),
    .wrap_pulse(b_wrap_pulse), .wrap_count(b_wrap_count), .err_flag(b_err_flag),
    .err_count(b_err_count), .first_bad(b_first_bad));

  int total = 0;
  int bad = 0;

  int cfg_resync[2]  = '{1, 0};
  int cfg_hold[2]    = '{1, 0};
  int cfg_errmax[2]  = '{255, 3};
  int cfg_wrapmod[2] = '{256, 8};

  // Model state: 0 WAIT, 1 LOCK, 2 FAULT.
  int m_state[2], m_last[2], m_exp[2], m_wp[2], m_wc[2];
  int m_flag[2], m_cnt[2], m_fb[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_last[k] = 0; m_exp[k] = 0; m_wp[k] = 0;
      m_wc[k] = 0; m_flag[k] = 0; m_cnt[k] = 0; m_fb[k] = 0;
    end
  endtask

  task automatic model_clock();
    for (int k = 0; k < 2; k++) begin
      int v;
      bit err;
      v = int'(count_in);
      err = 1'b0;
      m_wp[k] = 0;
      if (clear_err) begin
        m_flag[k] = 0; m_cnt[k] = 0; m_fb[k] = 0; m_state[k] = 0;
      end else if (sample_en) begin
        case (m_state[k])
          0: begin
            if (v % 2 == 1) err = 1'b1;
            else begin
              m_last[k] = v; m_exp[k] = (v + STEP) % 32; m_state[k] = 1;
            end
          end
          1: begin
            if (v == m_exp[k]) begin
              if (v < m_last[k]) begin
                m_wp[k] = 1;
                m_wc[k] = (m_wc[k] + 1) % cfg_wrapmod[k];
              end
              m_last[k] = v; m_exp[k] = (v + STEP) % 32;
            end else if (!(cfg_hold[k] != 0 && v == m_last[k])) begin
              err = 1'b1;
              if (cfg_resync[k] == 0) m_state[k] = 2;
              else if (v % 2 == 1) m_state[k] = 0;
              else begin
                m_last[k] = v; m_exp[k] = (v + STEP) % 32;
              end
            end
          end
          default: ;
        endcase
        if (err) begin
          if (m_cnt[k] < cfg_errmax[k]) m_cnt[k]++;
          if (m_flag[k] == 0) m_fb[k] = v;
          m_flag[k] = 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_locked",   32'(a_locked),     32'(m_state[0] == 1));
    chk("a_state",    32'(a_state),      m_state[0]);
    chk("a_expected", 32'(a_expected),   m_exp[0]);
    chk("a_wrap_p",   32'(a_wrap_pulse), m_wp[0]);
    chk("a_wrap_cnt", 32'(a_wrap_count), m_wc[0]);
    chk("a_err_flag", 32'(a_err_flag),   m_flag[0]);
    chk("a_err_cnt",  32'(a_err_count),  m_cnt[0]);
    chk("a_first_bad",32'(a_first_bad),  m_fb[0]);
    chk("b_locked",   32'(b_locked),     32'(m_state[1] == 1));
    chk("b_state",    32'(b_state),      m_state[1]);
    chk("b_expected", 32'(b_expected),   m_exp[1]);
    chk("b_wrap_p",   32'(b_wrap_pulse), m_wp[1]);
    chk("b_wrap_cnt", 32'(b_wrap_count), m_wc[1]);
    chk("b_err_flag", 32'(b_err_flag),   m_flag[1]);
    chk("b_err_cnt",  32'(b_err_count),  m_cnt[1]);
    chk("b_first_bad",32'(b_first_bad),  m_fb[1]);
  endtask

  // Inputs change 1 time unit after an edge; outputs are checked 1 unit after the next.
  task automatic drive(input logic [4:0] v, input logic se, input logic clr);
    count_in = v; sample_en = se; clear_err = clr;
    @(posedge clk);
    if (reset) model_clock();
    #1 check_all();
  endtask

  task automatic feed(input int v);
    drive(5'(v), 1'b1, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (5) @(posedge clk);
    #1 check_all();
    reset = 1'b1;

    // Full sequence with one wrap.
    feed(0);
    chk("p1_locked_after_first", 32'(a_locked), 32'd1);
    for (int v = 2; v <= 30; v += 2) feed(v);
    feed(0);
    chk("p1_wrap_pulse", 32'(a_wrap_pulse), 32'd1);
    feed(2);
    chk("p1_wrap_pulse_gone", 32'(a_wrap_pulse), 32'd0);
    chk("p1_wrap_count", 32'(a_wrap_count), 32'd1);
    chk("p1_expected", 32'(a_expected), 32'd4);
    chk("p1_err_count", 32'(a_err_count), 32'd0);

    // Held upstream value is tolerated.
    drive(5'd0, 1'b0, 1'b1);
    feed(0); feed(0); feed(0); feed(2); feed(4);
    chk("p2_err_count", 32'(a_err_count), 32'd0);
    chk("p2_expected", 32'(a_expected), 32'd6);

    // Relock on an even mismatch.
    drive(5'd0, 1'b0, 1'b1);
    feed(4); feed(6); feed(12); feed(14);
    chk("p3_err_count", 32'(a_err_count), 32'd1);
    chk("p3_first_bad", 32'(a_first_bad), 32'd12);
    chk("p3_err_flag", 32'(a_err_flag), 32'd1);
    chk("p3_state", 32'(a_state), 32'd1);
    chk("p3_expected", 32'(a_expected), 32'd16);

    // Odd value drops to WAIT; first_bad keeps the first error.
    drive(5'd0, 1'b0, 1'b1);
    feed(4); feed(7);
    chk("p4_state_wait", 32'(a_state), 32'd0);
    feed(8);
    chk("p4_state_lock", 32'(a_state), 32'd1);
    chk("p4_expected", 32'(a_expected), 32'd10);
    feed(3);
    chk("p4_first_bad", 32'(a_first_bad), 32'd7);
    chk("p4_err_count", 32'(a_err_count), 32'd2);

    // No-relock copy faults and stops counting; clear beats a mismatch.
    drive(5'd0, 1'b0, 1'b1);
    feed(0); feed(6);
    chk("p5_fault", 32'(b_state), 32'd2);
    feed(9); feed(12);
    chk("p5_fault_no_count", 32'(b_err_count), 32'd1);
    drive(5'd5, 1'b1, 1'b1);
    chk("p5_clear_cnt", 32'(b_err_count), 32'd0);
    chk("p5_clear_flag", 32'(b_err_flag), 32'd0);
    chk("p5_clear_state", 32'(b_state), 32'd0);

    // Saturation of the 2-bit error counter.
    feed(1); feed(3); feed(5); feed(7); feed(9);
    chk("p6_sat_b", 32'(b_err_count), 32'd3);
    chk("p6_cnt_a", 32'(a_err_count), 32'd5);
    feed(10); feed(12);
    #3 reset = 1'b0;
    model_reset();
    #1 check_all();
    chk("p6_async_locked", 32'(a_locked), 32'd0);
    drive(5'd4, 1'b1, 1'b0);
    drive(5'd6, 1'b1, 1'b0);
    reset = 1'b1;

    // Randomized mix of good steps, holds, glitches, idles and clears.
    for (int i = 0; i < 3000; i++) begin
      int r, sel;
      logic [4:0] v;
      r = int'($urandom_range(0, 99));
      sel = int'($urandom_range(0, 99));
      if (sel < 80)      v = 5'(m_exp[0]);
      else if (sel < 88) v = 5'(m_last[0]);
      else if (sel < 94) v = 5'($urandom_range(0, 15) * 2);
      else               v = 5'($urandom_range(0, 31));
      drive(v, r < 90, r == 99);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
